// File: rtl/target_pkg.sv
// rtl/target_pkg.sv - shared types and constants for the reaction-round judge
package target_pkg;

  typedef enum logic [2:0] {IDLE, GAP, ARM, WAIT} judge_state_t;

  // Fibonacci feedback taps for x^16+x^14+x^13+x^11+1 (register bits 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR, loads seed on reset
module lfsr16
  import target_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= seed;
    else        q <= {q[14:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/target_judge.sv
// rtl/target_judge.sv - one reaction round per pass: gap, pick target, light LED, judge press
module target_judge
  import target_pkg::*;
#(
  parameter int          N_TARGETS   = 4,
  parameter int          TIMEOUT_CYC = 50_000_000,
  parameter int          GAP_CYC     = 25_000_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N_TARGETS-1:0] sw,
  output logic [N_TARGETS-1:0] led,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic                 busy
);

  localparam int IW   = $clog2(N_TARGETS);
  localparam int MAXC = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int TW   = $clog2(MAXC);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  judge_state_t         state, state_n;
  logic [TW-1:0]        timer, timer_n;
  logic [N_TARGETS-1:0] sw_q;
  logic [N_TARGETS-1:0] rise;
  logic [N_TARGETS-1:0] tmask;
  logic [IW-1:0]        prev_idx, raw_idx, pick_idx;
  logic                 idx_load;
  logic                 hit_n, miss_n;
  logic [15:0]          lfsr_q;
  logic                 unused_lfsr;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:IW];
  assign raw_idx     = lfsr_q[IW-1:0];
  // Never repeat the previous target; N_TARGETS is a power of 2 so +1 wraps naturally.
  assign pick_idx    = (raw_idx == prev_idx) ? raw_idx + 1'b1 : raw_idx;

  // prev_idx doubles as the current target while in WAIT.
  assign tmask = {{(N_TARGETS-1){1'b0}}, 1'b1} << prev_idx;
  assign rise  = sw & ~sw_q;

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    idx_load = 1'b0;
    hit_n    = 1'b0;
    miss_n   = 1'b0;
    if (!start) begin
      state_n = IDLE;
      timer_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = GAP;
          timer_n = '0;
        end
        GAP: begin
          if (timer == GAP_LAST) begin
            state_n = ARM;
            timer_n = '0;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        ARM: begin
          if (sw == '0) begin
            idx_load = 1'b1;
            timer_n  = '0;
            state_n  = WAIT;
          end
        end
        WAIT: begin
          if (|(rise & ~tmask)) begin
            miss_n  = 1'b1;
            state_n = GAP;
            timer_n = '0;
          end else if (rise == tmask) begin
            hit_n   = 1'b1;
            state_n = GAP;
            timer_n = '0;
          end else if (timer == TO_LAST) begin
            miss_n  = 1'b1;
            state_n = GAP;
            timer_n = '0;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          timer_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      sw_q       <= '0;
      prev_idx   <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      sw_q       <= sw;
      hit_pulse  <= hit_n;
      miss_pulse <= miss_n;
      if (idx_load) prev_idx <= pick_idx;
    end
  end

  assign led  = (state == WAIT) ? tmask : '0;
  assign busy = (state != IDLE);

endmodule
